cfa_diag_tap_gen: RTL and testbench
===================================

CFA_DIAG_TAP_GEN -- requirements
Module: cfa_diag_tap_gen

Interface
REQ-001 The module SHALL have parameter IMG_W, default 64, giving pixels per line (minimum 3).
REQ-002 The module SHALL have parameter IMG_H, default 64, giving lines per frame (minimum 3).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an input pixel pair is present.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the module accepts the input pair this cycle.
REQ-007 The module SHALL have port g_in, input, 12 bits: interpolated green-plane sample, raster order.
REQ-008 The module SHALL have port rb_in, input, 12 bits: raw Bayer R/B-plane sample, same raster position as g_in.
REQ-009 The module SHALL have ports G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1, outputs, 12 bits each: green diagonal taps (first index row offset, second index column offset; m1 = -1, p1 = +1).
REQ-010 The module SHALL have ports RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1, outputs, 12 bits each: R/B diagonal taps, same offset convention.
REQ-011 The module SHALL have ports out_x and out_y, outputs, 16 bits each: column and row of the window centre.
REQ-012 The module SHALL have port out_valid, output, 1 bit: the tap set is valid.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the tap set.

Function
REQ-014 Transfer rules:
- An input SHALL be accepted when in_valid && in_ready.
- An output SHALL be consumed when out_valid && out_ready.
REQ-015 in_ready SHALL equal out_ready || !out_valid (single output register, no skid buffer).
REQ-016 Input position counters SHALL track the pixel being accepted:
- x advances 0..IMG_W-1 per accept and wraps to 0.
- y increments when x wraps, and wraps to 0 after (IMG_W-1, IMG_H-1).
- A new frame SHALL then start with no idle cycle.
REQ-017 Line storage SHALL be two line buffers of IMG_W entries x 24 bits ({g,rb}), plus a 3-row x 3-column window of shift registers.
- The window SHALL shift only on an input accept.
REQ-018 Emission trigger: accepting pixel (x,y) with x>=2 and y>=2 SHALL load the output register on the next edge with centre (x-1, y-1).
REQ-019 Tap mapping for that centre:
- m1_m1 = (y-2, x-2)
- m1_p1 = (y-2, x)
- p1_m1 = (y, x-2)
- p1_p1 = (y, x)
- G taps from g_in history, RB taps from rb_in history.
REQ-020 Border pixels (x or y = 0 or max) SHALL never be window centres; each frame SHALL emit exactly (IMG_W-2)*(IMG_H-2) tap sets.
REQ-021 Latency: out_valid SHALL rise one cycle after the triggering accept.
REQ-022 Output hold: while out_valid && !out_ready, all outputs SHALL hold stable and in_ready SHALL be 0, so no input is lost.
REQ-023 Simultaneous consume and trigger in one cycle SHALL reload the register with out_valid staying 1 (full throughput, one set per clock).
REQ-024 A consume with no trigger SHALL clear out_valid.
REQ-025 Stale window and line-buffer data from the previous row or frame SHALL never appear in an emitted set (guaranteed by REQ-018).
REQ-026 The module SHALL perform no arithmetic on samples; taps SHALL be bit-exact copies of the inputs.

Reset
REQ-027 On rst=1 at a clock edge:
- x, y, out_valid and all tap, out_x and out_y outputs SHALL become 0.
- in_ready SHALL read 1 in the following cycle.
REQ-028 Line buffer and window contents SHALL NOT require clearing.
REQ-029 Reset mid-frame SHALL abandon the frame; the next accepted pixel SHALL be (0,0) of a new frame.

Verification
REQ-030 Ramp frame: IMG_W=4, IMG_H=4, g=4y+x, rb=100+4y+x, out_ready=1, in_valid=1 -> four sets:
- (1,1): G 0,2,8,10; RB 100,102,108,110.
- (2,1): G 1,3,9,11.
- (1,2): G 4,6,12,14.
- (2,2): G 5,7,13,15.
REQ-031 Back-to-back frames: two ramp frames with no gap -> the second frame's four sets are identical to the first; no set contains frame-1 bottom rows.
REQ-032 Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> outputs constant, in_ready=0, no set dropped or duplicated; total still 4 per frame.
REQ-033 Input gaps: in_valid randomly 0 for 50% of cycles -> same four sets, in order, as REQ-030.
REQ-034 Mid-frame reset: rst pulsed after pixel (3,2) -> out_valid=0 next cycle; a following full ramp frame gives exactly the REQ-030 results.
REQ-035 Max values: all inputs 4095 -> every tap 4095; out_x and out_y cover 1..IMG_W-2 and 1..IMG_H-2 at default parameters.

Source files
------------

// File: rtl/cfa_diag_tap_gen.sv
// Diagonal tap generator for CFA demosaicing: streams green and raw R/B planes
// through two line buffers and a 3x3 window, emitting the four diagonal neighbours of each interior pixel.
`timescale 1ns/1ps
module cfa_diag_tap_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] g_in,
    input  logic [11:0] rb_in,
    output logic [11:0] G_m1_m1,
    output logic [11:0] G_m1_p1,
    output logic [11:0] G_p1_m1,
    output logic [11:0] G_p1_p1,
    output logic [11:0] RB_m1_m1,
    output logic [11:0] RB_m1_p1,
    output logic [11:0] RB_p1_m1,
    output logic [11:0] RB_p1_p1,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int          AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

    logic [15:0]   x_r;
    logic [15:0]   y_r;
    logic [23:0]   lb1_r [0:IMG_W-1];
    logic [23:0]   lb2_r [0:IMG_W-1];
    logic [23:0]   win_r [0:2][0:2];

    logic [AW-1:0] col_s;
    logic [23:0]   cur_s;
    logic [23:0]   up1_s;
    logic [23:0]   up2_s;
    logic          accept_s;
    logic          consume_s;
    logic          trigger_s;
    logic [15:0]   x_next_s;
    logic [15:0]   y_next_s;

    assign in_ready = out_ready || !out_valid;

    // Handshake decode, line-buffer read and raster position advance
    always_comb begin
        col_s     = x_r[AW-1:0];
        cur_s     = {g_in, rb_in};
        up1_s     = lb1_r[col_s];
        up2_s     = lb2_r[col_s];
        accept_s  = in_valid && in_ready;
        consume_s = out_valid && out_ready;
        trigger_s = accept_s && (x_r >= 16'd2) && (y_r >= 16'd2);
        x_next_s  = x_r;
        y_next_s  = y_r;
        if (x_r == X_LAST) begin
            x_next_s = 16'd0;
            if (y_r == Y_LAST) begin
                y_next_s = 16'd0;
            end else begin
                y_next_s = y_r + 16'd1;
            end
        end else begin
            x_next_s = x_r + 16'd1;
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= 16'd0;
            y_r <= 16'd0;
        end else if (accept_s) begin
            x_r <= x_next_s;
            y_r <= y_next_s;
        end
    end

    // Line buffers and window; row 0 is the current line, row 2 is two lines up
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_r[col_s] <= cur_s;
            lb2_r[col_s] <= up1_s;
            for (int r = 0; r < 3; r++) begin
                win_r[r][2] <= win_r[r][1];
                win_r[r][1] <= win_r[r][0];
            end
            win_r[0][0] <= cur_s;
            win_r[1][0] <= up1_s;
            win_r[2][0] <= up2_s;
        end
    end

    // Output register: before the shift, win_r[*][1] holds column x-2 of its row
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            G_m1_m1   <= 12'd0;
            G_m1_p1   <= 12'd0;
            G_p1_m1   <= 12'd0;
            G_p1_p1   <= 12'd0;
            RB_m1_m1  <= 12'd0;
            RB_m1_p1  <= 12'd0;
            RB_p1_m1  <= 12'd0;
            RB_p1_p1  <= 12'd0;
            out_x     <= 16'd0;
            out_y     <= 16'd0;
        end else if (trigger_s) begin
            out_valid <= 1'b1;
            G_m1_m1   <= win_r[2][1][23:12];
            G_m1_p1   <= up2_s[23:12];
            G_p1_m1   <= win_r[0][1][23:12];
            G_p1_p1   <= g_in;
            RB_m1_m1  <= win_r[2][1][11:0];
            RB_m1_p1  <= up2_s[11:0];
            RB_p1_m1  <= win_r[0][1][11:0];
            RB_p1_p1  <= rb_in;
            out_x     <= x_r - 16'd1;
            out_y     <= y_r - 16'd1;
        end else if (consume_s) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cfa_diag_tap_gen.sv
// Self-checking bench for cfa_diag_tap_gen: a 4x4 instance checked against a frame-image
// scoreboard plus literal ramp results, and a default-size instance driven with saturated samples.
`timescale 1ns/1ps
module tb_cfa_diag_tap_gen;
    typedef struct packed {
        logic [11:0] g_mm, g_mp, g_pm, g_pp;
        logic [11:0] r_mm, r_mp, r_pm, r_pp;
        logic [15:0] cx, cy;
    } set_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [11:0] g_in, rb_in;
    logic [11:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
    logic [11:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
    logic [15:0] out_x, out_y;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [11:0] t2_g_mm, t2_g_mp, t2_g_pm, t2_g_pp;
    logic [11:0] t2_r_mm, t2_r_mp, t2_r_pm, t2_r_pp;
    logic [15:0] out_x2, out_y2;

    cfa_diag_tap_gen #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .g_in(g_in), .rb_in(rb_in),
        .G_m1_m1(G_m1_m1), .G_m1_p1(G_m1_p1), .G_p1_m1(G_p1_m1), .G_p1_p1(G_p1_p1),
        .RB_m1_m1(RB_m1_m1), .RB_m1_p1(RB_m1_p1), .RB_p1_m1(RB_p1_m1), .RB_p1_p1(RB_p1_p1),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready)
    );

    cfa_diag_tap_gen dut_max (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .g_in(12'hfff), .rb_in(12'hfff),
        .G_m1_m1(t2_g_mm), .G_m1_p1(t2_g_mp), .G_p1_m1(t2_g_pm), .G_p1_p1(t2_g_pp),
        .RB_m1_m1(t2_r_mm), .RB_m1_p1(t2_r_mp), .RB_p1_m1(t2_r_pm), .RB_p1_p1(t2_r_pp),
        .out_x(out_x2), .out_y(out_y2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic set_t cur_set();
        set_t s;
        s.g_mm = G_m1_m1;  s.g_mp = G_m1_p1;  s.g_pm = G_p1_m1;  s.g_pp = G_p1_p1;
        s.r_mm = RB_m1_m1; s.r_mp = RB_m1_p1; s.r_pm = RB_p1_m1; s.r_pp = RB_p1_p1;
        s.cx = out_x; s.cy = out_y;
        return s;
    endfunction

    // Scoreboard: whole-frame image; each accepted interior-trigger pixel yields one expected set
    logic [11:0] img_g  [0:3][0:3];
    logic [11:0] img_rb [0:3][0:3];
    set_t exp_q [$];
    set_t log_set [0:127];
    int   log_n = 0;
    int   mx = 0;
    int   my = 0;
    bit   stall_prev = 1'b0;
    set_t held;

    always @(negedge clk) begin
        set_t e;
        chk("in_ready_rule", in_ready, out_ready || !out_valid);
        chk("out_valid_vs_model", out_valid, exp_q.size() != 0);
        if (stall_prev) chk("hold_stable", cur_set(), held);
        if (out_valid && out_ready) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tap_set", cur_set(), e);
            end else begin
                chk("unexpected_set", exp_q.size(), 1);
            end
            if (log_n < 128) log_set[log_n] = cur_set();
            log_n++;
        end
        stall_prev = out_valid && !out_ready;
        held = cur_set();
        if (rst) begin
            exp_q.delete();
            mx = 0;
            my = 0;
            stall_prev = 1'b0;
        end else if (in_valid && in_ready) begin
            img_g[my][mx]  = g_in;
            img_rb[my][mx] = rb_in;
            if (mx >= 2 && my >= 2) begin
                e.g_mm = img_g[my-2][mx-2];  e.g_mp = img_g[my-2][mx];
                e.g_pm = img_g[my][mx-2];    e.g_pp = img_g[my][mx];
                e.r_mm = img_rb[my-2][mx-2]; e.r_mp = img_rb[my-2][mx];
                e.r_pm = img_rb[my][mx-2];   e.r_pp = img_rb[my][mx];
                e.cx = 16'(mx - 1);
                e.cy = 16'(my - 1);
                exp_q.push_back(e);
            end
            mx = mx + 1;
            if (mx == 4) begin
                mx = 0;
                my = (my + 1) % 4;
            end
        end
    end

    // Saturated default-size instance: every tap all-ones, centres span the interior
    int n2 = 0;
    int acc2 = 0;
    int min_x2 = 99999, max_x2 = -1, min_y2 = 99999, max_y2 = -1;

    always @(negedge clk) begin
        chk("max_in_ready", in_ready2, out_ready2 || !out_valid2);
        if (!rst && in_valid2 && in_ready2) acc2++;
        if (out_valid2 && out_ready2) begin
            n2++;
            chk("max_taps", t2_g_mm & t2_g_mp & t2_g_pm & t2_g_pp & t2_r_mm & t2_r_mp & t2_r_pm & t2_r_pp,
                12'hfff);
            if (int'(out_x2) < min_x2) min_x2 = int'(out_x2);
            if (int'(out_x2) > max_x2) max_x2 = int'(out_x2);
            if (int'(out_y2) < min_y2) min_y2 = int'(out_y2);
            if (int'(out_y2) > max_y2) max_y2 = int'(out_y2);
        end
    end

    int ramp_g  [16] = '{0, 2, 8, 10, 1, 3, 9, 11, 4, 6, 12, 14, 5, 7, 13, 15};
    int ramp_cx [4]  = '{1, 2, 1, 2};
    int ramp_cy [4]  = '{1, 1, 2, 2};

    task automatic check_ramp(input int base);
        set_t s;
        for (int k = 0; k < 4; k++) begin
            s = log_set[(base + k) % 128];
            chk("ramp_g_mm", s.g_mm, ramp_g[4*k]);
            chk("ramp_g_mp", s.g_mp, ramp_g[4*k+1]);
            chk("ramp_g_pm", s.g_pm, ramp_g[4*k+2]);
            chk("ramp_g_pp", s.g_pp, ramp_g[4*k+3]);
            chk("ramp_rb_mm", s.r_mm, ramp_g[4*k] + 100);
            chk("ramp_rb_mp", s.r_mp, ramp_g[4*k+1] + 100);
            chk("ramp_rb_pm", s.r_pm, ramp_g[4*k+2] + 100);
            chk("ramp_rb_pp", s.r_pp, ramp_g[4*k+3] + 100);
            chk("ramp_cx", s.cx, ramp_cx[k]);
            chk("ramp_cy", s.cy, ramp_cy[k]);
        end
    endtask

    task automatic send_pix(input logic [11:0] g, input logic [11:0] rb, input bit gap);
        int w;
        if (gap) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        g_in = g;
        rb_in = rb;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 64) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // mode 0: ramp, 1: ramp with random input gaps, 2: random samples
    task automatic feed_frame(input int mode, input int n_pix);
        logic [11:0] g, rb;
        for (int i = 0; i < n_pix; i++) begin
            if (mode == 2) begin
                g  = 12'($urandom());
                rb = 12'($urandom());
            end else begin
                g  = 12'(i);
                rb = 12'(100 + i);
            end
            send_pix(g, rb, mode == 1);
        end
    endtask

    task automatic stall_until_valid();
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk("stall_sees_valid", out_valid, 1'b1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; g_in = 12'd0; rb_in = 12'd0; out_ready = 1'b1;
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_taps", cur_set(), 128'd0);
        chk("rst_max_out_valid", out_valid2, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // back-to-back ramp frames
        base = log_n;
        feed_frame(0, 16);
        feed_frame(0, 16);
        drain();
        chk("b2b_count", log_n - base, 8);
        check_ramp(base);
        check_ramp(base + 4);

        // backpressure held from the first set for five cycles
        base = log_n;
        out_ready = 1'b0;
        fork
            feed_frame(0, 16);
            stall_until_valid();
        join
        drain();
        chk("bp_count", log_n - base, 4);
        check_ramp(base);

        // random input gaps
        base = log_n;
        feed_frame(1, 16);
        drain();
        chk("gap_count", log_n - base, 4);
        check_ramp(base);

        // random samples, scoreboard only
        base = log_n;
        feed_frame(2, 16);
        drain();
        chk("rand_count", log_n - base, 4);

        // reset right after pixel (3,2)
        feed_frame(0, 12);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_taps", cur_set(), 128'd0);
        base = log_n;
        feed_frame(0, 16);
        drain();
        chk("midrst_count", log_n - base, 4);
        check_ramp(base);

        // saturated default-size frame, continuous input
        in_valid2 = 1'b1;
        repeat (4096) @(posedge clk);
        #1 in_valid2 = 1'b0;
        drain();
        chk("max_accepts", acc2, 4096);
        chk("max_count", n2, 3844);
        chk("max_min_x", min_x2, 1);
        chk("max_max_x", max_x2, 62);
        chk("max_min_y", min_y2, 1);
        chk("max_max_y", max_y2, 62);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
